hazard_scoreboard_unit: RTL and testbench

- Parametrised successor to the combinational hazard detector.
- Keeps a per-register countdown scoreboard, so stalls are correct for any load latency and any branch-resolve depth.
- Handles memory back-pressure and branch-taken flushes.
- Sits beside the IF/ID/EX/MEM pipeline registers and drives their stall and flush enables.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_sb_entry.sv | 29 ++
 rtl/hazard_scoreboard_unit.sv | 148 ++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and sizing helpers for the hazard scoreboard.
// Optional perf counters are enabled by HAZARD_PERF_CNT_EN.
package hazard_pkg;

  typedef enum logic [1:0] {
    NONE        = 2'd0,
    DATA        = 2'd1,
    BRANCH_DATA = 2'd2,
    MEM_WAIT    = 2'd3
  } hazard_cause_t;

  function automatic int cnt_w(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: countdown of cycles until a register's
// pending result is forwardable.
import hazard_pkg::*;

module hazard_sb_entry #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set,
  input  logic [W-1:0] set_val,
  input  logic         freeze,
  output logic [W-1:0] cnt
);

  // set wins over the decrement of the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (set) begin
        cnt <= set_val;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Countdown-scoreboard hazard unit driving pipeline stall/flush enables.
// Define HAZARD_PERF_CNT_EN to add saturating perf counter outputs.
import hazard_pkg::*;

module hazard_scoreboard_unit #(
  parameter int NUM_REGS     = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int ALU_LAT      = 0,
  parameter int LOAD_LAT     = 1,
  parameter int BRANCH_DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_branch,
  input  logic                  branch_taken,
  input  logic                  mem_ready,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]           perf_data_stalls,
  output logic [31:0]           perf_branch_stalls,
  output logic [31:0]           perf_mem_stalls,
  output logic [31:0]           perf_flushes,
`endif
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_ex,
  output logic                  flush_id,
  output logic                  stall_all,
  output logic [1:0]            hazard_cause
);

  // sized for the larger of the two set values so ALU_LAT > LOAD_LAT fits
  localparam int MAXV  = ((LOAD_LAT > ALU_LAT) ? LOAD_LAT : ALU_LAT)
                       + BRANCH_DEPTH;
  localparam int CNT_W = cnt_w(MAXV);

  localparam logic [CNT_W-1:0] LD_SET  = CNT_W'(LOAD_LAT + BRANCH_DEPTH);
  localparam logic [CNT_W-1:0] ALU_SET = CNT_W'(ALU_LAT + BRANCH_DEPTH);
  localparam logic [CNT_W-1:0] BD_C    = CNT_W'(BRANCH_DEPTH);

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] set_val;
  logic [CNT_W-1:0] c1;
  logic [CNT_W-1:0] c2;
  logic             issue;
  logic             hot1;
  logic             hot2;
  logic             data_haz;
  logic             br_haz;
  hazard_cause_t    cause;

  assign cnt[0]  = '0;
  assign set_val = id_mem_read ? LD_SET : ALU_SET;
  assign issue   = id_valid & ~stall_id & ~flush_id & ~stall_all;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_sb
      logic set;
      assign set = issue & id_reg_write
                 & (id_rd_addr == REG_ADDR_W'(r));
      hazard_sb_entry #(
        .W(CNT_W)
      ) u_entry (
        .clk    (clk),
        .rst    (rst),
        .set    (set),
        .set_val(set_val),
        .freeze (stall_all),
        .cnt    (cnt[r])
      );
    end
  endgenerate

  // addresses beyond NUM_REGS read as idle
  always_comb begin
    c1 = '0;
    c2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (id_rs1_addr == REG_ADDR_W'(i)) c1 = cnt[i];
      if (id_rs2_addr == REG_ADDR_W'(i)) c2 = cnt[i];
    end
  end

  assign hot1 = id_valid & id_uses_rs1 & (id_rs1_addr != '0);
  assign hot2 = id_valid & id_uses_rs2 & (id_rs2_addr != '0);

  assign data_haz = ~id_branch
                  & ((hot1 & (c1 > BD_C)) | (hot2 & (c2 > BD_C)));
  assign br_haz   = id_branch
                  & ((hot1 & (c1 != '0)) | (hot2 & (c2 != '0)));

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_id  = 1'b0;
    stall_all = 1'b0;
    cause     = NONE;
    if (rst) begin
      cause = NONE;
    end else if (!mem_ready) begin
      stall_all = 1'b1;
      cause     = MEM_WAIT;
    end else if (branch_taken) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (data_haz | br_haz) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
      cause    = br_haz ? BRANCH_DATA : DATA;
    end
  end

  assign hazard_cause = cause;

`ifdef HAZARD_PERF_CNT_EN
  logic fl_evt;
  assign fl_evt = ~rst & mem_ready & branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_data_stalls   <= '0;
      perf_branch_stalls <= '0;
      perf_mem_stalls    <= '0;
      perf_flushes       <= '0;
    end else begin
      if (cause == DATA && perf_data_stalls != '1)
        perf_data_stalls <= perf_data_stalls + 1'b1;
      if (cause == BRANCH_DATA && perf_branch_stalls != '1)
        perf_branch_stalls <= perf_branch_stalls + 1'b1;
      if (cause == MEM_WAIT && perf_mem_stalls != '1)
        perf_mem_stalls <= perf_mem_stalls + 1'b1;
      if (fl_evt && perf_flushes != '1)
        perf_flushes <= perf_flushes + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Vector-table bench for hazard_scoreboard_unit with an expectation queue.
// Perf outputs are checked at reset when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] id_rd_addr;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       id_branch;
  logic       branch_taken;
  logic       mem_ready;
  logic       stall_if;
  logic       stall_id;
  logic       flush_ex;
  logic       flush_id;
  logic       stall_all;
  logic [1:0] hazard_cause;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_data_stalls;
  logic [31:0] perf_branch_stalls;
  logic [31:0] perf_mem_stalls;
  logic [31:0] perf_flushes;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard_unit dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid          (id_valid),
    .id_rs1_addr       (id_rs1_addr),
    .id_rs2_addr       (id_rs2_addr),
    .id_uses_rs1       (id_uses_rs1),
    .id_uses_rs2       (id_uses_rs2),
    .id_rd_addr        (id_rd_addr),
    .id_reg_write      (id_reg_write),
    .id_mem_read       (id_mem_read),
    .id_branch         (id_branch),
    .branch_taken      (branch_taken),
    .mem_ready         (mem_ready),
`ifdef HAZARD_PERF_CNT_EN
    .perf_data_stalls  (perf_data_stalls),
    .perf_branch_stalls(perf_branch_stalls),
    .perf_mem_stalls   (perf_mem_stalls),
    .perf_flushes      (perf_flushes),
`endif
    .stall_if          (stall_if),
    .stall_id          (stall_id),
    .flush_ex          (flush_ex),
    .flush_id          (flush_id),
    .stall_all         (stall_all),
    .hazard_cause      (hazard_cause)
  );

  // {stall_if, stall_id, flush_ex, flush_id, stall_all, cause}
  localparam logic [6:0] E_NONE = 7'b00000_00;
  localparam logic [6:0] E_DATA = 7'b11100_01;
  localparam logic [6:0] E_BR   = 7'b11100_10;
  localparam logic [6:0] E_MEM  = 7'b00001_11;
  localparam logic [6:0] E_FL   = 7'b00110_00;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
    logic       bt;
    logic       mrdy;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t       tbl[$];
  logic [6:0] expq[$];
  string      nameq[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic vec_t op(input logic [4:0] rd, input logic rw,
                              input logic mr, input logic br,
                              input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2,
                              input logic [6:0] e, input string n);
    vec_t t;
    t.v = 1'b1; t.rd = rd; t.rw = rw; t.mr = mr; t.br = br;
    t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
    t.bt = 1'b0; t.mrdy = 1'b1; t.exp = e; t.name = n;
    return t;
  endfunction

  function automatic vec_t nop(input string n);
    vec_t t;
    t = op(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, E_NONE, n);
    t.v = 1'b0;
    return t;
  endfunction

  function automatic vec_t ctl(input vec_t t, input logic bt,
                               input logic mrdy);
    vec_t o;
    o = t; o.bt = bt; o.mrdy = mrdy;
    return o;
  endfunction

  task automatic drive(input vec_t t);
    id_valid     = t.v;
    id_rs1_addr  = t.rs1;
    id_uses_rs1  = t.u1;
    id_rs2_addr  = t.rs2;
    id_uses_rs2  = t.u2;
    id_rd_addr   = t.rd;
    id_reg_write = t.rw;
    id_mem_read  = t.mr;
    id_branch    = t.br;
    branch_taken = t.bt;
    mem_ready    = t.mrdy;
    expq.push_back(t.exp);
    nameq.push_back(t.name);
  endtask

  task automatic check_out();
    logic [6:0] got;
    logic [6:0] e;
    string      n;
    got = {stall_if, stall_id, flush_ex, flush_id, stall_all, hazard_cause};
    e = expq.pop_front();
    n = nameq.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", n, got, e);
    end
  endtask

  task automatic nops2();
    tbl.push_back(nop("gap"));
    tbl.push_back(nop("gap"));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t t;
    rst = 1'b1;
    drive(ctl(op(5'd1, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd1, 1'b1,
                 E_NONE, "reset_outputs"), 1'b1, 1'b0));
    #1 check_out();
`ifdef HAZARD_PERF_CNT_EN
    n_cmp++;
    if ({perf_data_stalls, perf_branch_stalls,
         perf_mem_stalls, perf_flushes} !== '0) begin
      n_bad++;
      $display("FAIL perf_reset: got %h %h %h %h expected 0",
               perf_data_stalls, perf_branch_stalls,
               perf_mem_stalls, perf_flushes);
    end
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    tbl.push_back(nop("idle"));
    // load-use: one stall then issue
    tbl.push_back(op(5'd5, 1, 1, 0, 5'd0, 0, 5'd0, 0, E_NONE, "ld_x5"));
    tbl.push_back(op(5'd6, 1, 0, 0, 5'd5, 1, 5'd0, 0, E_DATA, "lu_stall"));
    tbl.push_back(op(5'd6, 1, 0, 0, 5'd5, 1, 5'd0, 0, E_NONE, "lu_issue"));
    nops2();
    // alu then dependent alu: no stall
    tbl.push_back(op(5'd8, 1, 0, 0, 5'd0, 0, 5'd0, 0, E_NONE, "alu_x8"));
    tbl.push_back(op(5'd9, 1, 0, 0, 5'd0, 0, 5'd8, 1, E_NONE, "alu_alu"));
    nops2();
    // alu then branch: one stall
    tbl.push_back(op(5'd7, 1, 0, 0, 5'd0, 0, 5'd0, 0, E_NONE, "alu_x7"));
    tbl.push_back(op(5'd0, 0, 0, 1, 5'd1, 0, 5'd7, 1, E_BR, "ab_stall"));
    tbl.push_back(op(5'd0, 0, 0, 1, 5'd1, 0, 5'd7, 1, E_NONE, "ab_go"));
    nops2();
    // load then branch: two stalls
    tbl.push_back(op(5'd7, 1, 1, 0, 5'd0, 0, 5'd0, 0, E_NONE, "ld_x7"));
    tbl.push_back(op(5'd0, 0, 0, 1, 5'd0, 0, 5'd7, 1, E_BR, "lb_stall1"));
    tbl.push_back(op(5'd0, 0, 0, 1, 5'd0, 0, 5'd7, 1, E_BR, "lb_stall2"));
    tbl.push_back(op(5'd0, 0, 0, 1, 5'd0, 0, 5'd7, 1, E_NONE, "lb_go"));
    nops2();
    // memory wait freezes counters and masks branch_taken
    tbl.push_back(op(5'd3, 1, 1, 0, 5'd0, 0, 5'd0, 0, E_NONE, "ld_x3"));
    t = op(5'd4, 1, 0, 0, 5'd3, 1, 5'd0, 0, E_MEM, "mem_wait1");
    tbl.push_back(ctl(t, 1'b0, 1'b0));
    t.name = "mem_wait2";
    tbl.push_back(ctl(t, 1'b1, 1'b0));
    t.name = "mem_wait3";
    tbl.push_back(ctl(t, 1'b0, 1'b0));
    tbl.push_back(op(5'd4, 1, 0, 0, 5'd3, 1, 5'd0, 0, E_DATA, "mw_lu"));
    tbl.push_back(op(5'd4, 1, 0, 0, 5'd3, 1, 5'd0, 0, E_NONE, "mw_go"));
    nops2();
    // flush beats stall; squashed rd stays idle
    tbl.push_back(op(5'd9, 1, 1, 0, 5'd0, 0, 5'd0, 0, E_NONE, "ld_x9"));
    t = op(5'd10, 1, 0, 0, 5'd9, 1, 5'd0, 0, E_FL, "flush");
    tbl.push_back(ctl(t, 1'b1, 1'b1));
    tbl.push_back(op(5'd0, 0, 0, 1, 5'd10, 1, 5'd0, 0, E_NONE, "squash_rd"));
    nops2();
    // x0 never hazards
    tbl.push_back(op(5'd0, 1, 1, 0, 5'd0, 0, 5'd0, 0, E_NONE, "ld_x0"));
    tbl.push_back(op(5'd0, 0, 0, 1, 5'd0, 1, 5'd0, 1, E_NONE, "use_x0"));
    // re-issue reloads the full count
    tbl.push_back(op(5'd11, 1, 1, 0, 5'd0, 0, 5'd0, 0, E_NONE, "ld_x11"));
    tbl.push_back(op(5'd11, 1, 1, 0, 5'd0, 0, 5'd0, 0, E_NONE, "reld_x11"));
    tbl.push_back(op(5'd1, 1, 0, 0, 5'd11, 1, 5'd0, 0, E_DATA, "reld_use"));
    tbl.push_back(op(5'd1, 1, 0, 0, 5'd11, 1, 5'd0, 0, E_NONE, "reld_go"));
    nops2();

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1;
    end

    // asynchronous reset in the middle of a stall
    drive(op(5'd12, 1, 1, 0, 5'd0, 0, 5'd0, 0, E_NONE, "ld_x12"));
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
    t = op(5'd13, 1, 0, 0, 5'd12, 1, 5'd0, 0, E_DATA, "pre_rst");
    drive(t);
    #2 check_out();
    expq.push_back(E_NONE);
    nameq.push_back("rst_async");
    rst = 1'b1;
    #1 check_out();
    mem_ready = 1'b0;
    expq.push_back(E_NONE);
    nameq.push_back("rst_memwait");
    #1 check_out();
    mem_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    expq.push_back(E_NONE);
    nameq.push_back("rst_cnt_clr");
    @(negedge clk);
    check_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
